point_dispatcher: RTL and testbench

- Upstream sequencer for the cluster_PE tree.
- Reads data points from a single-port point memory and drives the root PE's control strobes (start_iter, receive_point, next_level, inc, update) plus point data.
- Repeats full passes over the data set until every PE reports stable, or until an iteration cap is reached.
- Sits between the host/top-level control and the root cluster_PE.

---
 rtl/kd_pkg.sv | 24 ++
 rtl/point_dispatcher_level_counter.sv | 28 ++
 rtl/point_dispatcher.sv | 195 +++++++++++++++++++
 tb/tb_point_dispatcher.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// Shared constants and dispatcher state type for the cluster_PE tree.
package kd_pkg;

  localparam int unsigned DIM         = 3;
  localparam int unsigned DATA_RANGE  = 255;
  localparam int unsigned DIM_SIZE    = $clog2(DATA_RANGE);
  localparam int unsigned CENTER_SIZE = DIM * DIM_SIZE;
  localparam int unsigned MAX_DEPTH   = 16;
  localparam int unsigned DEPTH_SIZE  = $clog2(MAX_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_WALK,
    S_ADD,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } disp_state_t;

endpackage

// File: rtl/point_dispatcher_level_counter.sv
// Loadable down-counter with zero flag; paces the next_level burst.
module level_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/point_dispatcher.sv
// Sequencer feeding the root cluster_PE: streams every point through the
// tree each pass and repeats passes until all PEs are stable or the cap hits.
module point_dispatcher
  import kd_pkg::*;
#(
  parameter int unsigned MAX_POINTS = 1024,
  parameter int unsigned ADDR_SIZE  = $clog2(MAX_POINTS),
  parameter int unsigned MAX_ITER   = 64,
  parameter int unsigned ITER_SIZE  = $clog2(MAX_ITER) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_SIZE:0]     num_points,
  input  logic [DEPTH_SIZE-1:0]  levels,
  input  logic                   all_stable,
  output logic                   mem_rd_en,
  output logic [ADDR_SIZE-1:0]   mem_addr,
  input  logic [CENTER_SIZE-1:0] mem_rd_data,
  output logic                   start_iter,
  output logic                   receive_point,
  output logic                   next_level,
  output logic                   inc,
  output logic                   update,
  output logic [CENTER_SIZE-1:0] point_out,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [ITER_SIZE-1:0]   iter_count
);

  localparam logic [ADDR_SIZE:0]   MAX_PTS_L = (ADDR_SIZE+1)'(MAX_POINTS);
  localparam logic [ITER_SIZE-1:0] ITER_CAP  = ITER_SIZE'(MAX_ITER);

  disp_state_t r_state, w_next;

  logic [ADDR_SIZE-1:0]   r_idx, w_idx;
  logic [ADDR_SIZE-1:0]   r_last, w_last;
  logic [DEPTH_SIZE-1:0]  r_levels, w_levels;
  logic [ADDR_SIZE:0]     w_nclamp;
  logic                   w_load, w_dec, w_zero;

  logic                   r_mem_rd_en, r_start_iter, r_receive_point;
  logic                   r_next_level, r_inc, r_update, r_busy, r_done, r_converged;
  logic [ADDR_SIZE-1:0]   r_mem_addr, w_mem_addr;
  logic [CENTER_SIZE-1:0] r_point_out, w_point_out;
  logic [ITER_SIZE-1:0]   r_iter_count, w_iter_count;
  logic                   w_converged;

  assign w_nclamp = (num_points > MAX_PTS_L) ? MAX_PTS_L : num_points;

  level_counter #(
    .WIDTH(DEPTH_SIZE)
  ) u_level_counter (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load),
    .i_value(r_levels - 1'b1),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  // Next state and next register values. Strobes are registered from the
  // next state so each one is high exactly while the FSM sits in its state.
  always_comb begin
    w_next       = r_state;
    w_idx        = r_idx;
    w_last       = r_last;
    w_levels     = r_levels;
    w_mem_addr   = r_mem_addr;
    w_point_out  = r_point_out;
    w_iter_count = r_iter_count;
    w_converged  = r_converged;
    w_load       = 1'b0;
    w_dec        = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_levels     = levels;
          w_last       = ADDR_SIZE'(w_nclamp - 1'b1);
          w_idx        = '0;
          w_iter_count = '0;
          w_converged  = 1'b0;
          w_next       = (num_points == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        w_idx  = '0;
        w_next = S_FETCH;
      end
      S_FETCH:  w_next = S_LATCH;
      S_LATCH: begin
        w_point_out = mem_rd_data;
        w_next      = S_SEND;
      end
      S_SEND: begin
        if (r_levels == '0) begin
          w_next = S_ADD;
        end else begin
          w_load = 1'b1;
          w_next = S_WALK;
        end
      end
      // Counter is loaded with levels-1, so the zero test on the last
      // pass yields exactly `levels` WALK cycles.
      S_WALK: begin
        if (w_zero) begin
          w_next = S_ADD;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_ADD: begin
        if (r_idx == r_last) begin
          w_next = S_UPDATE;
        end else begin
          w_idx  = r_idx + 1'b1;
          w_next = S_FETCH;
        end
      end
      S_UPDATE: w_next = S_CHECK;
      S_CHECK: begin
        w_iter_count = r_iter_count + 1'b1;
        if (all_stable) begin
          w_converged = 1'b1;
          w_next      = S_DONE;
        end else if (w_iter_count == ITER_CAP) begin
          w_converged = 1'b0;
          w_next      = S_DONE;
        end else begin
          w_next = S_START;
        end
      end
      default: w_next = S_IDLE;
    endcase

    if (w_next == S_FETCH) begin
      w_mem_addr = w_idx;
    end
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_last          <= '0;
      r_levels        <= '0;
      r_mem_rd_en     <= 1'b0;
      r_mem_addr      <= '0;
      r_start_iter    <= 1'b0;
      r_receive_point <= 1'b0;
      r_next_level    <= 1'b0;
      r_inc           <= 1'b0;
      r_update        <= 1'b0;
      r_point_out     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_converged     <= 1'b0;
      r_iter_count    <= '0;
    end else begin
      r_state         <= w_next;
      r_idx           <= w_idx;
      r_last          <= w_last;
      r_levels        <= w_levels;
      r_mem_rd_en     <= (w_next == S_FETCH);
      r_mem_addr      <= w_mem_addr;
      r_start_iter    <= (w_next == S_START);
      r_receive_point <= (w_next == S_SEND);
      r_next_level    <= (w_next == S_WALK);
      r_inc           <= (w_next == S_ADD);
      r_update        <= (w_next == S_UPDATE);
      r_point_out     <= w_point_out;
      r_busy          <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done          <= (w_next == S_DONE);
      r_converged     <= w_converged;
      r_iter_count    <= w_iter_count;
    end
  end

  assign mem_rd_en     = r_mem_rd_en;
  assign mem_addr      = r_mem_addr;
  assign start_iter    = r_start_iter;
  assign receive_point = r_receive_point;
  assign next_level    = r_next_level;
  assign inc           = r_inc;
  assign update        = r_update;
  assign point_out     = r_point_out;
  assign busy          = r_busy;
  assign done          = r_done;
  assign converged     = r_converged;
  assign iter_count    = r_iter_count;

endmodule

// File: tb/tb_point_dispatcher.sv
// Scoreboard bench for point_dispatcher: expected strobe stream is queued
// per run, a negedge monitor pops and compares every observed strobe/done.
module tb_point_dispatcher;
  import kd_pkg::*;

  localparam int unsigned ADDR_SIZE = 10;
  localparam int unsigned ITER_SIZE = 3;

  localparam int K_START = 0;
  localparam int K_RECV  = 1;
  localparam int K_NL    = 2;
  localparam int K_INC   = 3;
  localparam int K_UPD   = 4;
  localparam int K_DONE  = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [ADDR_SIZE:0]     num_points = '0;
  logic [DEPTH_SIZE-1:0]  levels = '0;
  logic                   all_stable;
  logic                   mem_rd_en;
  logic [ADDR_SIZE-1:0]   mem_addr;
  logic [CENTER_SIZE-1:0] mem_rd_data = '0;
  logic                   start_iter, receive_point, next_level, inc, update;
  logic [CENTER_SIZE-1:0] point_out;
  logic                   busy, done, converged;
  logic [ITER_SIZE-1:0]   iter_count;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  ev_t  sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   upd_cnt = 0;
  int   stable_after = 0;
  logic prev_done = 1'b0;
  logic [CENTER_SIZE-1:0] mem [0:1023];

  point_dispatcher #(
    .MAX_ITER(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_points   (num_points),
    .levels       (levels),
    .all_stable   (all_stable),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .start_iter   (start_iter),
    .receive_point(receive_point),
    .next_level   (next_level),
    .inc          (inc),
    .update       (update),
    .point_out    (point_out),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .iter_count   (iter_count)
  );

  always #5 clk = ~clk;

  // Single-port memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // PE tree stand-in: reports stable once enough updates have been seen.
  always @(negedge clk) begin
    if (update) upd_cnt = upd_cnt + 1;
  end
  assign all_stable = (upd_cnt >= stable_after);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input logic [31:0] d);
    ev_t e;
    checks = checks + 1;
    if (sbq.size() == 0) begin
      errors = errors + 1;
      $display("FAIL sb_unexpected got kind %0d data %h expected nothing", k, d);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.data !== d) begin
        errors = errors + 1;
        $display("FAIL sb_event got kind %0d data %h expected kind %0d data %h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every strobe cycle and every rising edge of done is an event.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones({start_iter, receive_point, next_level, inc, update}) > 1) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL strobe_exclusive got %b expected one-hot",
                 {start_iter, receive_point, next_level, inc, update});
      end else if (start_iter)    pop_cmp(K_START, '0);
      else if (receive_point)     pop_cmp(K_RECV, 32'(point_out));
      else if (next_level)        pop_cmp(K_NL, '0);
      else if (inc)               pop_cmp(K_INC, '0);
      else if (update)            pop_cmp(K_UPD, '0);
      if (done && !prev_done)     pop_cmp(K_DONE, {23'b0, converged, 5'b0, iter_count});
    end
    prev_done = done;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_pulse(input int n, input int l);
    num_points = (ADDR_SIZE+1)'(n);
    levels     = DEPTH_SIZE'(l);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Queue the full expected stream, launch, and time the run to done.
  task automatic run(input string name, input int n, input int l, input int k_stable,
                     input int exp_iters, input bit exp_conv);
    int np;
    int lat;
    int exp_lat;
    np = (n > 1024) ? 1024 : n;
    for (int it = 0; it < ((np == 0) ? 0 : exp_iters); it++) begin
      push(K_START, '0);
      for (int p = 0; p < np; p++) begin
        push(K_RECV, 32'(mem[p]));
        for (int j = 0; j < l; j++) push(K_NL, '0);
        push(K_INC, '0);
      end
      push(K_UPD, '0);
    end
    push(K_DONE, {23'b0, exp_conv, 5'b0, 3'(exp_iters)});
    stable_after = upd_cnt + k_stable;
    start_pulse(n, l);
    lat = 1;
    while (!done && lat < 30000) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = (np == 0) ? 1 : exp_iters * (1 + np * (l + 4) + 2) + 1;
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    chk({name, "_drained"}, 64'(sbq.size()), 64'd0);
    chk({name, "_idle_flags"}, {61'b0, busy, done, converged}, {61'b0, 1'b0, 1'b1, exp_conv});
  endtask

  initial begin
    int w;
    for (int i = 0; i < 1024; i++) mem[i] = 24'(i * 7 + 3);
    mem[0] = 24'd101;
    mem[1] = 24'hFFFFFF;
    mem[2] = 24'h123456;

    // Reset held two cycles with start asserted: must not launch.
    rst = 1'b1;
    start = 1'b1;
    num_points = 11'd2;
    levels = 4'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {57'b0, mem_rd_en, start_iter, receive_point, next_level, inc, update, busy},
        64'd0);
    chk("reset_status", {61'b0, done, converged, 1'b0}, 64'd0);
    chk("reset_point", 64'(point_out), 64'd0);
    chk("reset_addr_iter", {51'b0, mem_addr, iter_count}, 64'd0);
    @(negedge clk);
    chk("reset_start_ignored", {62'b0, busy, done}, 64'd0);

    run("basic", 2, 3, 1, 1, 1'b1);
    run("three_iter", 2, 3, 3, 3, 1'b1);
    run("iter_cap", 2, 3, 1000000, 4, 1'b0);

    // Abort mid-WALK, then rerun from idx 0.
    push(K_START, '0);
    push(K_RECV, 32'(mem[0]));
    push(K_NL, '0);
    start_pulse(2, 3);
    w = 0;
    while (!next_level && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("abort_walk_reached", 64'(next_level), 64'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {54'b0, mem_rd_en, start_iter, receive_point, next_level, inc, update,
                          busy, done, converged, 1'b0}, 64'd0);
    chk("abort_iter", 64'(iter_count), 64'd0);
    chk("abort_drained", 64'(sbq.size()), 64'd0);
    rst = 1'b0;
    run("rerun", 2, 3, 1, 1, 1'b1);

    do_reset();
    run("zero_points", 0, 3, 1, 0, 1'b0);
    run("zero_levels", 3, 0, 1, 1, 1'b1);
    run("clamp", 2047, 0, 1, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
